// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycast column pipeline.
// Holds the column record layout, the solid-wall palette and RGB565 shading.
package raycast_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StEmit,
      StTexReq,
      StTexWait,
      StFrameHold
   } state_e;

   // Fixed-width low part of a column record: {wallType, mapData[3:0], wallX[15:0]}.
   localparam int unsigned WallXW      = 16;
   localparam int unsigned MapW        = 4;
   localparam int unsigned WallXLsb    = 0;
   localparam int unsigned MapLsb      = WallXLsb + WallXW;
   localparam int unsigned WallTypeBit = MapLsb + MapW;
   localparam int unsigned LhLsb       = WallTypeBit + 1;

   localparam logic [15:0] PaletteMap1    = 16'h0000;
   localparam logic [15:0] PaletteMap2    = 16'h7670;
   localparam logic [15:0] PaletteDefault = 16'h0000;

   function automatic logic [15:0] palette_lookup(input logic [MapW-1:0] map);
      logic [15:0] pix;
      case (map)
         4'd1:    pix = PaletteMap1;
         4'd2:    pix = PaletteMap2;
         default: pix = PaletteDefault;
      endcase
      return pix;
   endfunction

   // Halve each RGB565 channel independently so no bit bleeds between fields.
   function automatic logic [15:0] rgb565_shade(input logic [15:0] pix);
      return {1'b0, pix[15:12], 1'b0, pix[10:6], 1'b0, pix[4:1]};
   endfunction

endpackage

// File: rtl/column_span_calc.sv
// Wall span for one column: centred on the screen middle, clamped to the screen,
// plus the unclamped signed start needed by the texture unit.
module column_span_calc #(
   parameter int unsigned SCREEN_HEIGHT = 180,
   parameter int unsigned HC_W          = 9,
   parameter int unsigned LH_W          = 8
) (
   input  logic        [LH_W-1:0] i_line_height,
   output logic        [HC_W-1:0] o_draw_start,
   output logic        [HC_W-1:0] o_draw_end,
   output logic signed [HC_W:0]   o_start_signed
);

   localparam logic [HC_W:0] Mid    = (HC_W+1)'(SCREEN_HEIGHT / 2);
   localparam logic [HC_W:0] Height = (HC_W+1)'(SCREEN_HEIGHT);

   logic [HC_W:0] w_half;
   logic [HC_W:0] w_end_raw;

   assign w_half         = (HC_W+1)'(i_line_height >> 1);
   assign o_start_signed = $signed(Mid - w_half);
   assign w_end_raw      = Mid + w_half;

   assign o_draw_start = o_start_signed[HC_W] ? '0 : o_start_signed[HC_W-1:0];
   assign o_draw_end   = (w_end_raw > Height) ? Height[HC_W-1:0] : w_end_raw[HC_W-1:0];

endmodule

// File: rtl/column_flattener.sv
// Turns one DDA column record into SCREEN_HEIGHT framebuffer writes, fetching texels
// through a one-outstanding request/response handshake for textured walls.
module column_flattener
   import raycast_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH  = 320,
   parameter int unsigned SCREEN_HEIGHT = 180,
   parameter int unsigned HC_W          = 9,
   parameter int unsigned LH_W          = 8,
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned TEX_BASE      = 3,
   parameter logic [15:0] CEILING_COLOR = 16'hFFFF,
   parameter logic [15:0] FLOOR_COLOR   = 16'hFFFF,
   parameter bit          SHADE_EN      = 1'b1
) (
   input  logic                                pixel_clk_in,
   input  logic                                rst_n_in,
   input  logic                                col_tvalid_in,
   input  logic                                col_tlast_in,
   input  logic [HC_W+LH_W+20:0]               col_tdata_in,
   output logic                                col_tready_out,
   input  logic [1:0]                          fb_ready_to_switch_in,
   output logic                                tex_req_valid_out,
   input  logic                                tex_req_ready_in,
   output logic [16+LH_W+HC_W+1+HC_W+4-1:0]    tex_req_out,
   input  logic                                tex_resp_valid_in,
   input  logic [15:0]                         tex_pixel_in,
   output logic                                ray_valid_out,
   input  logic                                fb_ready_in,
   output logic [ADDR_W-1:0]                   ray_address_out,
   output logic [15:0]                         ray_pixel_out,
   output logic                                ray_last_pixel_out
);

   localparam int unsigned TexReqW = WallXW + LH_W + HC_W + 1 + HC_W + MapW;

   state_e r_state, w_state_d;

   logic                r_tready;
   logic [HC_W-1:0]     r_hcount;
   logic [LH_W-1:0]     r_lh;
   logic                r_wall_type;
   logic [MapW-1:0]     r_map;
   logic [WallXW-1:0]   r_wallx;
   logic                r_tlast;
   logic [HC_W-1:0]     r_vcount;
   logic [ADDR_W-1:0]   r_row_base;
   logic [TexReqW-1:0]  r_tex_req;
   logic                r_valid;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_pixel;
   logic                r_last;

   logic                w_accept;
   logic                w_load;
   logic [15:0]         w_load_pix;
   logic [HC_W-1:0]     w_draw_start;
   logic [HC_W-1:0]     w_draw_end;
   logic signed [HC_W:0] w_start_signed;
   logic                w_slot_free;
   logic                w_in_span;
   logic                w_textured;
   logic                w_last_row;
   logic [15:0]         w_wall_pix;
   logic [15:0]         w_tex_pix;
   logic [TexReqW-1:0]  w_tex_req_d;

   column_span_calc #(
      .SCREEN_HEIGHT(SCREEN_HEIGHT),
      .HC_W         (HC_W),
      .LH_W         (LH_W)
   ) u_span (
      .i_line_height (r_lh),
      .o_draw_start  (w_draw_start),
      .o_draw_end    (w_draw_end),
      .o_start_signed(w_start_signed)
   );

   assign w_slot_free = !r_valid || fb_ready_in;
   assign w_in_span   = (r_vcount >= w_draw_start) && (r_vcount < w_draw_end);
   assign w_textured  = (r_map >= MapW'(TEX_BASE));
   assign w_last_row  = (r_vcount == HC_W'(SCREEN_HEIGHT - 1));
   assign w_tex_req_d = {r_wallx, r_lh, w_start_signed, r_vcount, r_map};

   always_comb begin
      w_wall_pix = (r_map == '0) ? CEILING_COLOR : palette_lookup(r_map);
      if (SHADE_EN && r_wall_type && (r_map != '0)) begin
         w_wall_pix = rgb565_shade(w_wall_pix);
      end
      w_tex_pix = (SHADE_EN && r_wall_type) ? rgb565_shade(tex_pixel_in) : tex_pixel_in;
   end

   always_comb begin
      w_state_d  = r_state;
      w_accept   = 1'b0;
      w_load     = 1'b0;
      w_load_pix = '0;
      unique case (r_state)
         StIdle: begin
            if (col_tvalid_in && r_tready) begin
               w_accept  = 1'b1;
               w_state_d = StEmit;
            end
         end
         StEmit: begin
            // Texture fetch only starts once the output slot is free, so the
            // returning texel always has somewhere to go.
            if (w_slot_free) begin
               if (w_in_span && w_textured) begin
                  w_state_d = StTexReq;
               end else begin
                  w_load = 1'b1;
                  if (w_in_span) begin
                     w_load_pix = w_wall_pix;
                  end else if (r_vcount < w_draw_start) begin
                     w_load_pix = CEILING_COLOR;
                  end else begin
                     w_load_pix = FLOOR_COLOR;
                  end
               end
            end
         end
         StTexReq: begin
            if (tex_req_ready_in) begin
               w_state_d = StTexWait;
            end
         end
         StTexWait: begin
            if (tex_resp_valid_in) begin
               w_load     = 1'b1;
               w_load_pix = w_tex_pix;
            end
         end
         StFrameHold: begin
            if ((fb_ready_to_switch_in == 2'b11) && w_slot_free) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
      if (w_load) begin
         if (w_last_row) begin
            w_state_d = r_tlast ? StFrameHold : StIdle;
         end else begin
            w_state_d = StEmit;
         end
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state     <= StIdle;
         r_tready    <= 1'b0;
         r_hcount    <= '0;
         r_lh        <= '0;
         r_wall_type <= 1'b0;
         r_map       <= '0;
         r_wallx     <= '0;
         r_tlast     <= 1'b0;
         r_vcount    <= '0;
         r_row_base  <= '0;
         r_tex_req   <= '0;
         r_valid     <= 1'b0;
         r_addr      <= '0;
         r_pixel     <= '0;
         r_last      <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_tready <= (w_state_d == StIdle);
         if (w_accept) begin
            r_hcount    <= col_tdata_in[LhLsb+LH_W +: HC_W];
            r_lh        <= col_tdata_in[LhLsb +: LH_W];
            r_wall_type <= col_tdata_in[WallTypeBit];
            r_map       <= col_tdata_in[MapLsb +: MapW];
            r_wallx     <= col_tdata_in[WallXLsb +: WallXW];
            r_tlast     <= col_tlast_in;
            r_vcount    <= '0;
            r_row_base  <= '0;
         end
         if ((w_state_d == StTexReq) && (r_state != StTexReq)) begin
            r_tex_req <= w_tex_req_d;
         end
         if (w_load) begin
            r_valid    <= 1'b1;
            r_addr     <= ADDR_W'(r_hcount) + r_row_base;
            r_pixel    <= w_load_pix;
            r_last     <= w_last_row && r_tlast;
            r_vcount   <= w_last_row ? '0 : r_vcount + HC_W'(1);
            r_row_base <= r_row_base + ADDR_W'(SCREEN_WIDTH);
         end else if (fb_ready_in) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   assign col_tready_out     = r_tready;
   assign tex_req_valid_out  = (r_state == StTexReq);
   assign tex_req_out        = r_tex_req;
   assign ray_valid_out      = r_valid;
   assign ray_address_out    = r_addr;
   assign ray_pixel_out      = r_pixel;
   assign ray_last_pixel_out = r_last;

endmodule

// File: tb/tb_column_flattener.sv
// Directed bench for column_flattener: span/colour vectors, texture handshake,
// framebuffer back-pressure, end-of-frame hold and mid-column reset.
module tb_column_flattener;

   logic        pixel_clk_in;
   logic        rst_n_in;
   logic        col_tvalid_in;
   logic        col_tlast_in;
   logic [37:0] col_tdata_in;
   logic        col_tready_out;
   logic [1:0]  fb_ready_to_switch_in;
   logic        tex_req_valid_out;
   logic        tex_req_ready_in;
   logic [46:0] tex_req_out;
   logic        tex_resp_valid_in;
   logic [15:0] tex_pixel_in;
   logic        ray_valid_out;
   logic        fb_ready_in;
   logic [15:0] ray_address_out;
   logic [15:0] ray_pixel_out;
   logic        ray_last_pixel_out;

   int n_tests = 0;
   int n_fail  = 0;
   int req_cycles;
   int lastbad;

   logic [15:0] addr_q[$];
   logic [15:0] pix_q[$];
   bit          last_q[$];
   int          cyc_q[$];
   logic [46:0] exp_req;

   column_flattener u_dut (
      .pixel_clk_in         (pixel_clk_in),
      .rst_n_in             (rst_n_in),
      .col_tvalid_in        (col_tvalid_in),
      .col_tlast_in         (col_tlast_in),
      .col_tdata_in         (col_tdata_in),
      .col_tready_out       (col_tready_out),
      .fb_ready_to_switch_in(fb_ready_to_switch_in),
      .tex_req_valid_out    (tex_req_valid_out),
      .tex_req_ready_in     (tex_req_ready_in),
      .tex_req_out          (tex_req_out),
      .tex_resp_valid_in    (tex_resp_valid_in),
      .tex_pixel_in         (tex_pixel_in),
      .ray_valid_out        (ray_valid_out),
      .fb_ready_in          (fb_ready_in),
      .ray_address_out      (ray_address_out),
      .ray_pixel_out        (ray_pixel_out),
      .ray_last_pixel_out   (ray_last_pixel_out)
   );

   initial pixel_clk_in = 1'b0;
   always #5 pixel_clk_in = ~pixel_clk_in;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d",
               n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge pixel_clk_in);
      #1;
   endtask

   task automatic send(input logic [8:0] hc, input logic [7:0] lh, input logic wt,
                       input logic [3:0] map, input logic [15:0] wx, input logic tlast);
      int c;
      c = 0;
      col_tdata_in  = {hc, lh, wt, map, wx};
      col_tlast_in  = tlast;
      col_tvalid_in = 1'b1;
      while (!col_tready_out && c < 50) begin
         step();
         c++;
      end
      check("send_tready", 64'(col_tready_out), 64'd1);
      step();
      col_tvalid_in = 1'b0;
      check("tready_drop", 64'(col_tready_out), 64'd0);
   endtask

   // Collects n completed beats; optionally stalls fb_ready_in for 4 cycles at beat stall_at.
   task automatic drain(input int n, input int stall_at);
      int          cyc;
      int          stall_left;
      bit          stalled;
      logic [15:0] h_a;
      logic [15:0] h_p;
      cyc = 0; stall_left = 0; stalled = 0; h_a = '0; h_p = '0;
      addr_q.delete(); pix_q.delete(); last_q.delete(); cyc_q.delete();
      while (addr_q.size() < n && cyc < 2000) begin
         if (stall_at >= 0 && !stalled && ray_valid_out && addr_q.size() == stall_at) begin
            stalled    = 1'b1;
            stall_left = 4;
            h_a        = ray_address_out;
            h_p        = ray_pixel_out;
         end
         if (stall_left > 0) begin
            fb_ready_in = 1'b0;
            if (stall_left < 4) begin
               check("stall_valid", 64'(ray_valid_out), 64'd1);
               check("stall_addr", 64'(ray_address_out), 64'(h_a));
               check("stall_pix", 64'(ray_pixel_out), 64'(h_p));
            end
            stall_left--;
         end else begin
            fb_ready_in = 1'b1;
         end
         if (ray_last_pixel_out && !ray_valid_out) lastbad++;
         if (tex_req_valid_out) req_cycles++;
         if (ray_valid_out && fb_ready_in) begin
            addr_q.push_back(ray_address_out);
            pix_q.push_back(ray_pixel_out);
            last_q.push_back(ray_last_pixel_out);
            cyc_q.push_back(cyc);
         end
         step();
         cyc++;
      end
      check("drain_count", 64'(addr_q.size()), 64'(n));
      fb_ready_in = 1'b1;
   endtask

   task automatic wait_req();
      int c;
      c = 0;
      while (!tex_req_valid_out && c < 20) begin
         step();
         c++;
      end
      check("req_seen", 64'(tex_req_valid_out), 64'd1);
   endtask

   initial begin
      rst_n_in = 1'b0; col_tvalid_in = 1'b0; col_tlast_in = 1'b0; col_tdata_in = '0;
      fb_ready_to_switch_in = 2'b00; tex_req_ready_in = 1'b0; tex_resp_valid_in = 1'b0;
      tex_pixel_in = '0; fb_ready_in = 1'b1; req_cycles = 0; lastbad = 0;
      #1;
      check("rst_tready", 64'(col_tready_out), 64'd0);
      check("rst_valid", 64'(ray_valid_out), 64'd0);
      check("rst_addr", 64'(ray_address_out), 64'd0);
      check("rst_pix", 64'(ray_pixel_out), 64'd0);
      check("rst_last", 64'(ray_last_pixel_out), 64'd0);
      check("rst_treq_v", 64'(tex_req_valid_out), 64'd0);
      check("rst_treq", 64'(tex_req_out), 64'd0);
      step(); step();
      rst_n_in = 1'b1;
      check("rel_tready0", 64'(col_tready_out), 64'd0);
      step();
      check("rel_tready1", 64'(col_tready_out), 64'd1);

      // Solid map 1, span 40..139, one pixel per cycle
      send(9'd5, 8'd100, 1'b0, 4'd1, 16'h0, 1'b0);
      drain(180, -1);
      for (int i = 0; i < 180; i++) begin
         check("t1_addr", 64'(addr_q[i]), 64'(5 + i * 320));
         check("t1_pix", 64'(pix_q[i]), (i >= 40 && i < 140) ? 64'h0 : 64'hFFFF);
      end
      check("t1_throughput", 64'(cyc_q[179] - cyc_q[0]), 64'd179);
      check("t1_tready", 64'(col_tready_out), 64'd1);

      // Tall wall clamps to full column, map 2 shaded
      send(9'd0, 8'd255, 1'b1, 4'd2, 16'h0, 1'b0);
      drain(180, -1);
      for (int i = 0; i < 180; i++) begin
         check("t2_addr", 64'(addr_q[i]), 64'(i * 320));
         check("t2_pix", 64'(pix_q[i]), 64'h3B28);
      end

      // Textured, two-pixel span at v89/v90
      send(9'd7, 8'd2, 1'b0, 4'd3, 16'h1234, 1'b0);
      req_cycles = 0;
      drain(89, -1);
      check("t3_no_early_req", 64'(req_cycles), 64'd0);
      for (int i = 0; i < 89; i++) begin
         check("t3_top_addr", 64'(addr_q[i]), 64'(7 + i * 320));
         check("t3_top_pix", 64'(pix_q[i]), 64'hFFFF);
      end
      wait_req();
      exp_req = {16'h1234, 8'd2, 10'd89, 9'd89, 4'd3};
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_v", 64'(tex_req_valid_out), 64'd1);
         check("t3_hold_req", 64'(tex_req_out), 64'(exp_req));
         tex_resp_valid_in = (i == 1);
         tex_pixel_in      = 16'h1111;
         step();
      end
      tex_resp_valid_in = 1'b0;
      check("t3_stale_ignored", 64'(ray_valid_out), 64'd0);
      tex_req_ready_in = 1'b1;
      check("t3_req", 64'(tex_req_out), 64'(exp_req));
      step();
      tex_req_ready_in = 1'b0;
      check("t3_req_drop", 64'(tex_req_valid_out), 64'd0);
      step();
      check("t3_wait_nobeat", 64'(ray_valid_out), 64'd0);
      tex_resp_valid_in = 1'b1;
      tex_pixel_in      = 16'hABCD;
      step();
      tex_resp_valid_in = 1'b0;
      check("t3_tex_valid", 64'(ray_valid_out), 64'd1);
      check("t3_tex_addr", 64'(ray_address_out), 64'd28487);
      check("t3_tex_pix", 64'(ray_pixel_out), 64'hABCD);
      drain(1, -1);
      wait_req();
      exp_req = {16'h1234, 8'd2, 10'd89, 9'd90, 4'd3};
      check("t3_req2", 64'(tex_req_out), 64'(exp_req));
      tex_req_ready_in = 1'b1;
      step();
      tex_req_ready_in  = 1'b0;
      tex_resp_valid_in = 1'b1;
      tex_pixel_in      = 16'h5678;
      step();
      tex_resp_valid_in = 1'b0;
      req_cycles = 0;
      drain(90, -1);
      check("t3_tex2_addr", 64'(addr_q[0]), 64'd28807);
      check("t3_tex2_pix", 64'(pix_q[0]), 64'h5678);
      for (int i = 1; i < 90; i++) begin
         check("t3_bot_addr", 64'(addr_q[i]), 64'(7 + (90 + i) * 320));
         check("t3_bot_pix", 64'(pix_q[i]), 64'hFFFF);
      end
      check("t3_only_two_reqs", 64'(req_cycles), 64'd0);

      // Back-pressure at v60
      send(9'd10, 8'd100, 1'b0, 4'd1, 16'h0, 1'b0);
      drain(180, 60);
      for (int i = 0; i < 180; i++) begin
         check("t4_addr", 64'(addr_q[i]), 64'(10 + i * 320));
         check("t4_pix", 64'(pix_q[i]), (i >= 40 && i < 140) ? 64'h0 : 64'hFFFF);
      end
      check("t4_cycles", 64'(cyc_q[179] - cyc_q[0]), 64'd183);

      // Last column of frame, zero line height on a textured map
      fb_ready_to_switch_in = 2'b01;
      req_cycles = 0;
      lastbad    = 0;
      send(9'd1, 8'd0, 1'b0, 4'd3, 16'h0, 1'b1);
      drain(180, -1);
      for (int i = 0; i < 180; i++) begin
         check("t5_last", 64'(last_q[i]), (i == 179) ? 64'd1 : 64'd0);
         check("t5_pix", 64'(pix_q[i]), 64'hFFFF);
      end
      check("t5_last_addr", 64'(addr_q[179]), 64'd57281);
      check("t5_no_req", 64'(req_cycles), 64'd0);
      check("t5_last_only_valid", 64'(lastbad), 64'd0);
      for (int i = 0; i < 10; i++) begin
         check("t5_hold_tready", 64'(col_tready_out), 64'd0);
         step();
      end
      fb_ready_to_switch_in = 2'b11;
      step();
      check("t5_switch_tready", 64'(col_tready_out), 64'd1);

      // Reset mid-column
      send(9'd2, 8'd100, 1'b0, 4'd1, 16'h0, 1'b0);
      drain(50, -1);
      rst_n_in = 1'b0;
      #1;
      check("t6_rst_valid", 64'(ray_valid_out), 64'd0);
      check("t6_rst_addr", 64'(ray_address_out), 64'd0);
      check("t6_rst_pix", 64'(ray_pixel_out), 64'd0);
      check("t6_rst_tready", 64'(col_tready_out), 64'd0);
      step(); step();
      rst_n_in = 1'b1;
      check("t6_rel_tready0", 64'(col_tready_out), 64'd0);
      step();
      check("t6_rel_tready1", 64'(col_tready_out), 64'd1);
      tex_resp_valid_in = 1'b1;
      tex_pixel_in      = 16'hDEAD;
      step();
      tex_resp_valid_in = 1'b0;
      check("t6_stale_resp", 64'(ray_valid_out), 64'd0);
      step();
      check("t6_no_partial", 64'(ray_valid_out), 64'd0);
      send(9'd3, 8'd100, 1'b0, 4'd2, 16'h0, 1'b0);
      drain(180, -1);
      check("t6_addr0", 64'(addr_q[0]), 64'd3);
      check("t6_pix0", 64'(pix_q[0]), 64'hFFFF);
      check("t6_addr100", 64'(addr_q[100]), 64'd32003);
      check("t6_pix100", 64'(pix_q[100]), 64'h7670);
      check("t6_addr179", 64'(addr_q[179]), 64'd57283);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
